fir_stream: RTL

FIR_STREAM -- requirements
Module: fir_stream

---
 rtl/fir_pkg.sv | 14 +
 rtl/fir_stream_if.sv | 38 +++
 rtl/fir_mac.sv | 56 +++++
 rtl/fir_stream.sv | 117 +++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// Shared state type and width helpers for the multi-channel streaming FIR.
package fir_pkg;

    typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

    function automatic int ch_width(input int ch);
        return (ch > 1) ? $clog2(ch) : 1;
    endfunction

    function automatic int acc_width(input int width, input int cwidth, input int n);
        return width + cwidth + $clog2(n);
    endfunction

endpackage

// File: rtl/fir_stream_if.sv
// Sample stream, coefficient write port and result stream of fir_stream.
interface fir_stream_if
    import fir_pkg::*;
#(
    parameter int N      = 4,
    parameter int WIDTH  = 8,
    parameter int CWIDTH = 8,
    parameter int OWIDTH = 20,
    parameter int CH     = 2
);
    localparam int CW = ch_width(CH);
    localparam int KW = $clog2(N);

    logic                     in_valid;
    logic                     in_ready;
    logic [CW-1:0]            in_ch;
    logic signed [WIDTH-1:0]  sample_in;
    logic                     coef_we;
    logic [KW-1:0]            coef_addr;
    logic signed [CWIDTH-1:0] coef_data;
    logic                     coef_err;
    logic                     out_valid;
    logic                     out_ready;
    logic [CW-1:0]            out_ch;
    logic signed [OWIDTH-1:0] sample_out;
    logic                     sat;

    modport master (
        output in_valid, in_ch, sample_in, coef_we, coef_addr, coef_data, out_ready,
        input  in_ready, coef_err, out_valid, out_ch, sample_out, sat
    );

    modport slave (
        input  in_valid, in_ch, sample_in, coef_we, coef_addr, coef_data, out_ready,
        output in_ready, coef_err, out_valid, out_ch, sample_out, sat
    );

endinterface

// File: rtl/fir_mac.sv
// Signed multiply-accumulate datapath with output sign-extension or saturation.
module fir_mac #(
    parameter int WIDTH  = 8,
    parameter int CWIDTH = 8,
    parameter int OWIDTH = 20,
    parameter int AW     = 18
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_clear,
    input  logic                     i_en,
    input  logic signed [WIDTH-1:0]  i_x,
    input  logic signed [CWIDTH-1:0] i_c,
    output logic signed [OWIDTH-1:0] o_res,
    output logic                     o_sat
);
    localparam int PW = WIDTH + CWIDTH;

    logic signed [PW-1:0] w_prod;
    logic signed [AW-1:0] w_sum;
    logic signed [AW-1:0] r_acc;

    assign w_prod = i_x * i_c;
    assign w_sum  = r_acc + {{(AW-PW){w_prod[PW-1]}}, w_prod};

    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_acc <= '0;
        end else if (i_en) begin
            r_acc <= w_sum;
        end
    end

    // Result is taken from the sum including the final tap, so no extra cycle is spent.
    generate
        if (OWIDTH >= AW) begin : g_ext
            assign o_res = OWIDTH'(w_sum);
            assign o_sat = 1'b0;
        end else begin : g_clamp
            localparam logic signed [AW-1:0] MAXV = {{(AW-OWIDTH+1){1'b0}}, {(OWIDTH-1){1'b1}}};
            localparam logic signed [AW-1:0] MINV = {{(AW-OWIDTH+1){1'b1}}, {(OWIDTH-1){1'b0}}};
            always_comb begin
                o_res = w_sum[OWIDTH-1:0];
                o_sat = 1'b0;
                if (w_sum > MAXV) begin
                    o_res = MAXV[OWIDTH-1:0];
                    o_sat = 1'b1;
                end else if (w_sum < MINV) begin
                    o_res = MINV[OWIDTH-1:0];
                    o_sat = 1'b1;
                end
            end
        end
    endgenerate

endmodule

// File: rtl/fir_stream.sv
// Multi-channel time-multiplexed FIR: per-channel delay lines, shared coefficients, one MAC per cycle.
module fir_stream
    import fir_pkg::*;
#(
    parameter int N      = 4,
    parameter int WIDTH  = 8,
    parameter int CWIDTH = 8,
    parameter int OWIDTH = 20,
    parameter int CH     = 2
) (
    input logic        clk,
    input logic        rst,
    fir_stream_if.slave bus
);
    localparam int CW = ch_width(CH);
    localparam int AW = acc_width(WIDTH, CWIDTH, N);
    localparam int KW = $clog2(N);

    state_t                   r_state;
    logic [KW-1:0]            r_k;
    logic [CW-1:0]            r_ch;
    logic signed [WIDTH-1:0]  r_x [CH][N];
    logic signed [CWIDTH-1:0] r_coef [N];
    logic                     r_out_valid;
    logic [CW-1:0]            r_out_ch;
    logic signed [OWIDTH-1:0] r_sample_out;
    logic                     r_sat;
    logic                     r_coef_err;

    logic                     w_accept;
    logic                     w_coef_wr;
    logic                     w_last;
    logic signed [OWIDTH-1:0] w_res;
    logic                     w_sat;

    assign w_accept  = (r_state == IDLE) && bus.in_valid && (int'(bus.in_ch) < CH);
    assign w_coef_wr = (r_state == IDLE) && bus.coef_we && (int'(bus.coef_addr) < N);
    assign w_last    = (r_state == MAC) && (r_k == KW'(N - 1));

    fir_mac #(
        .WIDTH  (WIDTH),
        .CWIDTH (CWIDTH),
        .OWIDTH (OWIDTH),
        .AW     (AW)
    ) u_mac (
        .clk     (clk),
        .rst     (rst),
        .i_clear (w_accept),
        .i_en    (r_state == MAC),
        .i_x     (r_x[r_ch][r_k]),
        .i_c     (r_coef[r_k]),
        .o_res   (w_res),
        .o_sat   (w_sat)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_k          <= '0;
            r_ch         <= '0;
            r_out_valid  <= 1'b0;
            r_out_ch     <= '0;
            r_sample_out <= '0;
            r_sat        <= 1'b0;
            r_coef_err   <= 1'b0;
            for (int unsigned k = 0; k < N; k++) begin
                r_coef[k] <= CWIDTH'(1);
                for (int unsigned c = 0; c < CH; c++) begin
                    r_x[c][k] <= '0;
                end
            end
        end else begin
            r_coef_err <= bus.coef_we && (r_state != IDLE);
            if (w_coef_wr) begin
                r_coef[bus.coef_addr] <= bus.coef_data;
            end
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        for (int unsigned i = N - 1; i > 0; i--) begin
                            r_x[bus.in_ch][i] <= r_x[bus.in_ch][i-1];
                        end
                        r_x[bus.in_ch][0] <= bus.sample_in;
                        r_ch    <= bus.in_ch;
                        r_k     <= '0;
                        r_state <= MAC;
                    end
                end
                MAC: begin
                    r_k <= r_k + 1'b1;
                    if (w_last) begin
                        r_state      <= OUT;
                        r_out_valid  <= 1'b1;
                        r_sample_out <= w_res;
                        r_sat        <= w_sat;
                        r_out_ch     <= r_ch;
                    end
                end
                OUT: begin
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready   = (r_state == IDLE);
    assign bus.out_valid  = r_out_valid;
    assign bus.out_ch     = r_out_ch;
    assign bus.sample_out = r_sample_out;
    assign bus.sat        = r_sat;
    assign bus.coef_err   = r_coef_err;

endmodule
